// File: rtl/addr_phase_gen_if.sv
// Bus bundle for addr_phase_gen.
// master: control side (start/stop, burst length, tuning word load, optional phase offset).
// slave : the generator (address stream, valid/wrap/done flags, tuning-word ack).
// Optional phase_off signal exists only when ADDR_GEN_PHASE_OFFSET_EN is defined.
interface addr_phase_gen_if #(
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned BURST_WIDTH = 16
);
  logic                   start;
  logic                   stop;
  logic [BURST_WIDTH-1:0] burst_cnt;
  logic [ACC_WIDTH-1:0]   tw_in;
  logic                   tw_load;
  logic                   tw_ack;
  logic [ADDR_WIDTH-1:0]  addr_out;
  logic                   addr_valid;
  logic                   wrap_pulse;
  logic                   done;
  logic                   sample_valid;
`ifdef ADDR_GEN_PHASE_OFFSET_EN
  logic [ADDR_WIDTH-1:0]  phase_off;
`endif

  modport master (
`ifdef ADDR_GEN_PHASE_OFFSET_EN
    output phase_off,
`endif
    output start, stop, burst_cnt, tw_in, tw_load,
    input  tw_ack, addr_out, addr_valid, wrap_pulse, done, sample_valid
  );

  modport slave (
`ifdef ADDR_GEN_PHASE_OFFSET_EN
    input  phase_off,
`endif
    input  start, stop, burst_cnt, tw_in, tw_load,
    output tw_ack, addr_out, addr_valid, wrap_pulse, done, sample_valid
  );
endinterface

// File: rtl/addr_phase_gen.sv
// DDS-style read address generator for the waveform memory.
// The read address is the top ADDR_WIDTH bits of a phase accumulator stepped by the active
// tuning word. Supports start/stop, continuous or N-period burst playback, phase-continuous
// tuning-word updates (applied on accumulator carry while running), and a valid flag delayed
// by PIPE_DEPTH cycles to line up with the downstream address path.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - addr_phase_gen_if.slave (control inputs, address stream and status outputs)
// Optional feature: define ADDR_GEN_PHASE_OFFSET_EN to add bus.phase_off, a start-latched
// offset added (mod 2^ADDR_WIDTH) to the address; wrap/burst logic still uses acc carry only.
module addr_phase_gen #(
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned PIPE_DEPTH  = 10,
  parameter int unsigned BURST_WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  addr_phase_gen_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   tw_active_q, shadow_q;
  logic                   pending_q;
  logic [BURST_WIDTH-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   valid_q, valid_d;
  logic                   wrap_q, wrap_d;
  logic                   done_q, done_d;
  logic                   ack_q;
  logic [PIPE_DEPTH-1:0]  dly_q;

  logic                   carry;
  logic [ACC_WIDTH-1:0]   acc_sum;
  logic [BURST_WIDTH-1:0] wrap_cnt_inc;
  logic                   last_wrap;
  logic                   apply;
  logic [ADDR_WIDTH-1:0]  start_addr;
  logic [ADDR_WIDTH-1:0]  run_addr;

`ifdef ADDR_GEN_PHASE_OFFSET_EN
  logic [ADDR_WIDTH-1:0]  phase_q, phase_d;
  assign start_addr = bus.phase_off;
  assign run_addr   = acc_sum[ACC_WIDTH-1 -: ADDR_WIDTH] + phase_q;
`else
  assign start_addr = '0;
  assign run_addr   = acc_sum[ACC_WIDTH-1 -: ADDR_WIDTH];
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    wrap_cnt_d = wrap_cnt_q;
    burst_d    = burst_q;
    addr_d     = '0;
    valid_d    = 1'b0;
    wrap_d     = 1'b0;
    done_d     = 1'b0;
    apply      = 1'b0;
`ifdef ADDR_GEN_PHASE_OFFSET_EN
    phase_d    = phase_q;
`endif
    {carry, acc_sum} = {1'b0, acc_q} + {1'b0, tw_active_q};
    wrap_cnt_inc     = wrap_cnt_q + BURST_WIDTH'(1);
    last_wrap        = carry && (burst_q != '0) && (wrap_cnt_inc == burst_q);

    unique case (state_q)
      StIdle: begin
        apply = pending_q;
        // Stop wins over a simultaneous start.
        if (bus.start && !bus.stop) begin
          state_d    = StRun;
          acc_d      = '0;
          wrap_cnt_d = '0;
          burst_d    = bus.burst_cnt;
          addr_d     = start_addr;
          valid_d    = 1'b1;
`ifdef ADDR_GEN_PHASE_OFFSET_EN
          phase_d    = bus.phase_off;
`endif
        end
      end
      StRun: begin
        if (bus.stop) begin
          state_d = StIdle;
        end else begin
          acc_d  = acc_sum;
          wrap_d = carry;
          // New word takes effect from the increment after the carry: phase continuous.
          apply  = pending_q && carry;
          if (carry && (wrap_cnt_q != '1)) wrap_cnt_d = wrap_cnt_inc;
          if (last_wrap) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            addr_d  = run_addr;
            valid_d = 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      wrap_cnt_q <= '0;
      burst_q    <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ADDR_GEN_PHASE_OFFSET_EN
      phase_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      wrap_cnt_q <= wrap_cnt_d;
      burst_q    <= burst_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
`ifdef ADDR_GEN_PHASE_OFFSET_EN
      phase_q    <= phase_d;
`endif
    end
  end

  // Tuning-word shadow: a load coinciding with apply becomes the next pending word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tw_active_q <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      ack_q <= apply;
      if (apply) tw_active_q <= shadow_q;
      if (bus.tw_load) begin
        shadow_q  <= bus.tw_in;
        pending_q <= 1'b1;
      end else if (apply) begin
        pending_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_q <= '0;
    end else begin
      dly_q[0] <= valid_q;
      for (int i = 1; i < PIPE_DEPTH; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign bus.addr_out     = addr_q;
  assign bus.addr_valid   = valid_q;
  assign bus.wrap_pulse   = wrap_q;
  assign bus.done         = done_q;
  assign bus.tw_ack       = ack_q;
  assign bus.sample_valid = dly_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_addr_phase_gen.sv
module tb_addr_phase_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  addr_phase_gen_if #(.ACC_WIDTH(32), .ADDR_WIDTH(14), .BURST_WIDTH(16)) bus ();

  addr_phase_gen #(
    .ACC_WIDTH  (32),
    .ADDR_WIDTH (14),
    .PIPE_DEPTH (10),
    .BURST_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic        start;
    logic        stop;
    logic [15:0] burst;
    logic [31:0] tw;
    logic        tw_load;
    logic [13:0] addr;
    logic        valid;
    logic        wrap;
    logic        done;
    logic        ack;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic st, logic sp, logic [15:0] b, logic [31:0] tw, logic ld,
                              logic [13:0] a, logic v, logic w, logic d, logic k);
    vec_t r;
    r.start = st; r.stop = sp; r.burst = b; r.tw = tw; r.tw_load = ld;
    r.addr = a; r.valid = v; r.wrap = w; r.done = d; r.ack = k;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.start = 1'b0; bus.stop = 1'b0; bus.burst_cnt = '0; bus.tw_in = '0; bus.tw_load = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[31];
    int errs, serr, acks;

    drive_idle();
`ifdef ADDR_GEN_PHASE_OFFSET_EN
    bus.phase_off = '0;
`endif
    #2;
    chk("reset_outputs", {bus.addr_out, bus.addr_valid, bus.wrap_pulse, bus.done, bus.tw_ack,
                          bus.sample_valid}, '0);
    step();
    rst = 1'b0;

    //            st sp burst tw            ld addr   v  w  d  ack
    vecs[0]  = mk(0, 0, 0, 32'h4000_0000, 1, 0,     0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 32'h0,         0, 0,     0, 0, 0, 1);
    vecs[2]  = mk(1, 0, 2, 32'h0,         0, 0,     1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 32'h0,         0, 4096,  1, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,         0, 8192,  1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 32'h0,         0, 12288, 1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 32'h0,         0, 0,     1, 1, 0, 0);
    vecs[7]  = mk(0, 0, 0, 32'h0,         0, 4096,  1, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 32'h0,         0, 8192,  1, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 32'h0,         0, 12288, 1, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 32'h0,         0, 0,     0, 1, 1, 0);
    vecs[11] = mk(0, 0, 0, 32'h0,         0, 0,     0, 0, 0, 0);
    vecs[12] = mk(1, 1, 0, 32'h0,         0, 0,     0, 0, 0, 0);
    vecs[13] = mk(1, 0, 0, 32'h0,         0, 0,     1, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 32'h0,         0, 4096,  1, 0, 0, 0);
    vecs[15] = mk(0, 1, 0, 32'h0,         0, 0,     0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 32'h0,         0, 0,     0, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 32'h1000_0000, 1, 0,     0, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 32'h2000_0000, 1, 0,     0, 0, 0, 1);
    vecs[19] = mk(0, 0, 0, 32'h0,         0, 0,     0, 0, 0, 1);
    vecs[20] = mk(0, 0, 0, 32'h0,         0, 0,     0, 0, 0, 0);
    vecs[21] = mk(1, 0, 1, 32'h0,         0, 0,     1, 0, 0, 0);
    vecs[22] = mk(0, 0, 0, 32'h0,         0, 2048,  1, 0, 0, 0);
    vecs[23] = mk(0, 0, 0, 32'h0,         0, 4096,  1, 0, 0, 0);
    vecs[24] = mk(0, 0, 0, 32'h0,         0, 6144,  1, 0, 0, 0);
    vecs[25] = mk(0, 0, 0, 32'h0,         0, 8192,  1, 0, 0, 0);
    vecs[26] = mk(0, 0, 0, 32'h0,         0, 10240, 1, 0, 0, 0);
    vecs[27] = mk(0, 0, 0, 32'h0,         0, 12288, 1, 0, 0, 0);
    vecs[28] = mk(0, 0, 0, 32'h0,         0, 14336, 1, 0, 0, 0);
    vecs[29] = mk(0, 0, 0, 32'h0,         0, 0,     0, 1, 1, 0);
    vecs[30] = mk(0, 0, 0, 32'h0,         0, 0,     0, 0, 0, 0);

    for (int i = 0; i < 31; i++) begin
      bus.start = vecs[i].start; bus.stop = vecs[i].stop; bus.burst_cnt = vecs[i].burst;
      bus.tw_in = vecs[i].tw; bus.tw_load = vecs[i].tw_load;
      step();
      chk($sformatf("vec%0d", i),
          {bus.addr_out, bus.addr_valid, bus.wrap_pulse, bus.done, bus.tw_ack},
          {vecs[i].addr, vecs[i].valid, vecs[i].wrap, vecs[i].done, vecs[i].ack});
    end
    drive_idle();

    // Continuous playback, one address per cycle, plus sample_valid rise timing.
    bus.tw_in = 32'h0004_0000; bus.tw_load = 1'b1;
    step();
    bus.tw_load = 1'b0;
    chk("tw_pending_no_ack", bus.tw_ack, 0);
    step();
    chk("tw_apply_idle", bus.tw_ack, 1);
    for (int i = 0; i < 12; i++) step();
    bus.start = 1'b1;
    errs = 0; serr = 0;
    for (int k = 0; k <= 16384; k++) begin
      step();
      bus.start = 1'b0;
      if (bus.addr_out !== 14'(k) || bus.addr_valid !== 1'b1 || bus.wrap_pulse !== (k == 16384))
        errs++;
      if (bus.sample_valid !== (k >= 10)) serr++;
    end
    chk("cont_stream", errs, 0);
    chk("sample_valid_rise", serr, 0);
    chk("cont_wrap_second_zero", {bus.addr_out, bus.wrap_pulse}, {14'd0, 1'b1});

    // Phase-continuous tuning update with an overwritten shadow.
    errs = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (bus.addr_out !== 14'(k)) errs++;
    end
    chk("run_to_100", errs, 0);
    bus.tw_in = 32'h4000_0000; bus.tw_load = 1'b1;
    step();
    chk("tw_load_run_1", {bus.addr_out, bus.tw_ack}, {14'd101, 1'b0});
    bus.tw_in = 32'h8000_0000;
    step();
    bus.tw_load = 1'b0;
    chk("tw_load_run_2", {bus.addr_out, bus.tw_ack}, {14'd102, 1'b0});
    errs = 0; acks = 0;
    for (int a = 103; a <= 16383; a++) begin
      step();
      if (bus.addr_out !== 14'(a) || bus.wrap_pulse !== 1'b0) errs++;
      if (bus.tw_ack) acks++;
    end
    chk("old_word_until_wrap", errs, 0);
    chk("no_early_ack", acks, 0);
    step();
    chk("tw_apply_at_wrap", {bus.addr_out, bus.wrap_pulse, bus.tw_ack}, {14'd0, 1'b1, 1'b1});
    step();
    chk("new_word_1", {bus.addr_out, bus.wrap_pulse, bus.tw_ack}, {14'd8192, 1'b0, 1'b0});
    step();
    chk("new_word_2", {bus.addr_out, bus.wrap_pulse}, {14'd0, 1'b1});
    step();
    chk("new_word_3", {bus.addr_out, bus.wrap_pulse}, {14'd8192, 1'b0});
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("stop_run", {bus.addr_out, bus.addr_valid}, {14'd0, 1'b0});
    serr = 0;
    for (int j = 0; j <= 10; j++) begin
      if (j > 0) step();
      if (bus.sample_valid !== (j < 10)) serr++;
    end
    chk("sample_valid_fall", serr, 0);

    // Stop at address 500.
    bus.tw_in = 32'h0004_0000; bus.tw_load = 1'b1;
    step();
    bus.tw_load = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("restart_addr0", {bus.addr_out, bus.addr_valid}, {14'd0, 1'b1});
    for (int k = 0; k < 500; k++) step();
    chk("addr_500", bus.addr_out, 500);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("stop_at_500", {bus.addr_out, bus.addr_valid}, {14'd0, 1'b0});
    step();
    chk("idle_after_stop", {bus.addr_out, bus.addr_valid}, {14'd0, 1'b0});

    // Asynchronous reset mid-run.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("pre_reset_run", {bus.addr_out, bus.addr_valid}, {14'd4, 1'b1});
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {bus.addr_out, bus.addr_valid, bus.wrap_pulse, bus.done, bus.tw_ack,
                        bus.sample_valid}, '0);
    step();
    rst = 1'b0;
    errs = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (bus.addr_valid !== 1'b0 || bus.addr_out !== 14'd0) errs++;
    end
    chk("idle_after_reset", errs, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("tw_cleared_by_reset", {bus.addr_out, bus.addr_valid}, {14'd0, 1'b1});
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;

`ifdef ADDR_GEN_PHASE_OFFSET_EN
    bus.tw_in = 32'h0004_0000; bus.tw_load = 1'b1;
    step();
    bus.tw_load = 1'b0;
    step();
    bus.phase_off = 14'd16380;
    bus.start = 1'b1;
    errs = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      bus.start = 1'b0;
      if (bus.addr_out !== 14'(16380 + k) || bus.wrap_pulse !== 1'b0 || bus.addr_valid !== 1'b1)
        errs++;
    end
    chk("phase_offset_stream", errs, 0);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
